// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vm_pkg
// Purpose  : Shared definitions for the vending machine input datapath.
//            Input line count and the bit index of each physical line.
//            The downstream Boolean/selection logic uses the same indices, so
//            both sides stay in agreement.
// Contents :
//    N_IN_DEFAULT  number of conditioned input lines
//    IDX_A/B/C     bit position of each line inside an input vector
//    vm_in_t       packed vector holding one bit per input line
// Revision : 1.0 - initial release
// ============================================================================
package vm_pkg;

   localparam int N_IN_DEFAULT = 3;

   localparam int IDX_A = 0;
   localparam int IDX_B = 1;
   localparam int IDX_C = 2;

   typedef logic [N_IN_DEFAULT-1:0] vm_in_t;

   // Debounce counter width: enough bits to hold DB_CYCLES, and at least 1.
   function automatic int db_cnt_width(input int db_cycles);
      int w;
      w = $clog2(db_cycles + 1);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage : vm_pkg
`default_nettype wire

// File: rtl/btn_db_line.sv
`default_nettype none
// ============================================================================
// Module   : btn_db_line
// Purpose  : Conditions a single raw asynchronous button/sensor line.
//            Two-flop synchronizer, debounce counter that requires DB_CYCLES
//            consecutive disagreeing samples before the clean level flips, and
//            a registered rising-edge pulse.
//            Optional auto-repeat (macro BTN_AUTO_REPEAT_EN): while the clean
//            level stays high, rise_o re-fires every REPEAT_CYCLES cycles.
// Ports    :
//    clk        in   system clock, all state on the rising edge
//    rst_n      in   asynchronous active-low reset
//    raw_i      in   raw asynchronous line level
//    clean_o    out  debounced level (registered)
//    clean_d_o  out  next-state of clean_o, lets the parent register
//                    aggregate flags in the same cycle as clean_o
//    rise_o     out  one-cycle pulse aligned with clean_o going 0->1
//                    (plus auto-repeat pulses when enabled)
// Revision : 1.0 - initial release
// ============================================================================
module btn_db_line
   import vm_pkg::*;
#(
   parameter int DB_CYCLES     = 4,
   parameter int REPEAT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic clean_o,
   output logic clean_d_o,
   output logic rise_o
);

   localparam int              CNT_W      = db_cnt_width(DB_CYCLES);
   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

   // ------------------------------------------------------------------------
   // Synchronizer. sync1_q may be metastable; only sync2_q is used.
   // ------------------------------------------------------------------------
   logic sync1_q;
   logic sync2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // ------------------------------------------------------------------------
   // Debounce. The counter records how many consecutive edges the
   // synchronized level has disagreed with the clean level; any agreement
   // restarts qualification from zero.
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             clean_q;
   logic             clean_d;

   always_comb begin
      cnt_d   = cnt_q;
      clean_d = clean_q;
      if (sync2_q == clean_q) begin
         cnt_d = '0;
      end else if (cnt_q == c_CNT_LAST) begin
         clean_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + c_CNT_ONE;
      end
   end

   logic w_rise_edge;
   assign w_rise_edge = clean_d & ~clean_q;

   // ------------------------------------------------------------------------
   // Pulse source: true rising edge, optionally OR'ed with auto-repeat.
   // ------------------------------------------------------------------------
   logic rise_d;

`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [15:0] c_REP_LAST = 16'(REPEAT_CYCLES - 1);
   localparam logic [15:0] c_REP_ONE  = 16'd1;

   logic [15:0] rep_q;
   logic [15:0] rep_d;
   logic        w_rep_hit;

   // The counter only runs while the line stays high across an edge, so it
   // is zero on the 0->1 edge itself and zero whenever the line is low.
   always_comb begin
      rep_d     = '0;
      w_rep_hit = 1'b0;
      if (clean_q && clean_d) begin
         if (rep_q == c_REP_LAST) begin
            w_rep_hit = 1'b1;
         end else begin
            rep_d = rep_q + c_REP_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end

   assign rise_d = w_rise_edge | w_rep_hit;
`else
   assign rise_d = w_rise_edge;
`endif

   logic rise_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         clean_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         rise_q  <= rise_d;
      end
   end

   assign clean_o   = clean_q;
   assign clean_d_o = clean_d;
   assign rise_o    = rise_q;

endmodule : btn_db_line
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Input-conditioning stage ahead of the vending machine Boolean /
//            selection logic. Synchronizes and debounces N_IN raw lines
//            (bit 0 = A, bit 1 = B, bit 2 = C), presents clean levels, one-cycle
//            rising-edge pulses and a registered "any line active" flag.
//            Optional auto-repeat pulses: define BTN_AUTO_REPEAT_EN.
//            Ports are identical with and without the macro.
// Ports    :
//    clk         in   system clock, all state on the rising edge
//    rst_n       in   asynchronous active-low reset (release is synchronized
//                     by the surrounding reset tree)
//    raw_in      in   [N_IN] raw asynchronous levels
//    clean_out   out  [N_IN] debounced levels
//    rise_pulse  out  [N_IN] one-cycle 0->1 pulses (and auto-repeat)
//    any_active  out  OR of clean_out, registered alongside clean_out
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner
   import vm_pkg::*;
#(
   parameter int N_IN          = N_IN_DEFAULT,
   parameter int DB_CYCLES     = 4,
   parameter int REPEAT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_IN-1:0] raw_in,
   output logic [N_IN-1:0] clean_out,
   output logic [N_IN-1:0] rise_pulse,
   output logic            any_active
);

   logic [N_IN-1:0] w_clean;
   logic [N_IN-1:0] w_clean_next;
   logic [N_IN-1:0] w_rise;

   for (genvar gi = 0; gi < N_IN; gi++) begin : g_line
      btn_db_line #(
         .DB_CYCLES     (DB_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES)
      ) u_line (
         .clk       (clk),
         .rst_n     (rst_n),
         .raw_i     (raw_in[gi]),
         .clean_o   (w_clean[gi]),
         .clean_d_o (w_clean_next[gi]),
         .rise_o    (w_rise[gi])
      );
   end : g_line

   // Built from the next-state levels so the flag lands in the same cycle
   // as the clean_out bits it summarises.
   logic any_active_q;
   logic any_active_d;

   assign any_active_d = |w_clean_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_active_q <= 1'b0;
      end else begin
         any_active_q <= any_active_d;
      end
   end

   assign clean_out  = w_clean;
   assign rise_pulse = w_rise;
   assign any_active = any_active_q;

endmodule : btn_conditioner
`default_nettype wire
